// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store and fetch bus master for the multicycle core. It accepts one
//   access at a time and drives the shared memory bus, holding the bus through
//   wait states. It generates byte lanes and returns read data that is sign-
//   or zero-extended, along with an error flag.
//
// Build option:
//   MISALIGNED_SPLIT_EN - when defined, a misaligned access is performed on the
//   bus. If it crosses a bus-word boundary, it is split into two transfers.
//   When undefined, a misaligned access is answered with an error and causes
//   no bus activity.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   req_*                 valid/ready request: write, size, unsigned, addr, wdata
//   rsp_valid/rdata/error one-cycle response pulse, extended load data, error
//   memory_read/write     bus strobes, held until bus_ready
//   address, byte_enable  aligned bus address and active byte lanes
//   write_data            lane-shifted store data
//   bus_ready, read_data  bus completion and read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    memory_read,
    output logic                    memory_write,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   read_data
);

    localparam int B     = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(B);

    typedef enum logic [1:0] {IDLE, ACCESS_LO, ACCESS_HI, RESP} state_t;

    state_t           r_state;
    logic             r_write;
    logic             r_unsigned;
    logic [1:0]       r_size;
    logic [OFF_W-1:0] r_off;

    // ---------------- request decode (used only on accept) ----------------
    logic [OFF_W-1:0]      w_off;
    logic [2*B-1:0]        w_base;
    logic [2*B-1:0]        w_lanes;
    logic                  w_split;
    logic                  w_size_err;
    logic                  w_error;
    logic [DATA_WIDTH-1:0] w_wdata_lo;

    assign w_off = req_addr[OFF_W-1:0];

    always_comb begin
        case (req_size)
            2'd0:    w_base = (2*B)'(8'h01);
            2'd1:    w_base = (2*B)'(8'h03);
            2'd2:    w_base = (2*B)'(8'h0F);
            default: w_base = (2*B)'(8'hFF);
        endcase
    end

    // Lanes are computed over two bus words; any lane set in the upper word
    // means the access crosses into the next aligned word.
    assign w_lanes    = w_base << w_off;
    assign w_split    = |w_lanes[2*B-1:B];
    assign w_size_err = (DATA_WIDTH == 32) && (req_size == 2'd3);
    assign w_wdata_lo = req_wdata << {w_off, 3'b000};

`ifdef MISALIGNED_SPLIT_EN
    logic [DATA_WIDTH-1:0] w_wdata_hi;
    logic                  r_split;
    logic [B-1:0]          r_hi_be;
    logic [DATA_WIDTH-1:0] r_hi_wdata;
    logic [DATA_WIDTH-1:0] r_lo_data;

    // Bytes pushed past the top of the first word land in the second word.
    assign w_wdata_hi = req_wdata >> (DATA_WIDTH - 8 * int'(w_off));
    assign w_error    = w_size_err;
`else
    logic w_misaligned;

    always_comb begin
        case (req_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = w_off[0];
            2'd2:    w_misaligned = |w_off[1:0];
            default: w_misaligned = |w_off;
        endcase
    end

    // w_split is implied by w_misaligned here; it is kept in the error term so
    // that a crossing access can never reach the bus in this build.
    assign w_error = w_size_err | w_misaligned | w_split;
`endif

    // ---------------- load data path ----------------
    logic [DATA_WIDTH-1:0] w_aligned;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_sign;
    int                    w_nbytes;

`ifdef MISALIGNED_SPLIT_EN
    logic [DATA_WIDTH-1:0] w_lo_src;
    logic [DATA_WIDTH-1:0] w_hi_src;

    // The second transfer supplies the upper bytes. The first transfer's
    // lanes were captured in r_lo_data.
    assign w_lo_src  = (r_state == ACCESS_HI) ? r_lo_data : read_data;
    assign w_hi_src  = (r_state == ACCESS_HI) ? read_data : '0;
    assign w_aligned = (w_lo_src >> {r_off, 3'b000}) |
                       (w_hi_src << (DATA_WIDTH - 8 * int'(r_off)));
`else
    assign w_aligned = read_data >> {r_off, 3'b000};
`endif

    always_comb begin
        case (r_size)
            2'd0:    w_sign = w_aligned[7];
            2'd1:    w_sign = w_aligned[15];
            2'd2:    w_sign = w_aligned[31];
            default: w_sign = 1'b0;
        endcase
        w_sign   = w_sign & ~r_unsigned;
        w_nbytes = int'(1) << r_size;
        w_ext    = '0;
        for (int i = 0; i < B; i++) begin
            w_ext[8*i +: 8] = (i < w_nbytes) ? w_aligned[8*i +: 8] : {8{w_sign}};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'd0;
            r_off        <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            memory_read  <= 1'b0;
            memory_write <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            byte_enable  <= '0;
`ifdef MISALIGNED_SPLIT_EN
            r_split      <= 1'b0;
            r_hi_be      <= '0;
            r_hi_wdata   <= '0;
            r_lo_data    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_unsigned <= req_unsigned;
                        r_size     <= req_size;
                        r_off      <= w_off;
                        req_ready  <= 1'b0;
                        if (w_error) begin
                            r_state   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            r_state      <= ACCESS_LO;
                            memory_read  <= ~req_write;
                            memory_write <= req_write;
                            address      <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            byte_enable  <= w_lanes[B-1:0];
                            write_data   <= w_wdata_lo;
`ifdef MISALIGNED_SPLIT_EN
                            r_split    <= w_split;
                            r_hi_be    <= w_lanes[2*B-1:B];
                            r_hi_wdata <= w_wdata_hi;
`endif
                        end
                    end
                end
                ACCESS_LO, ACCESS_HI: begin
                    if (bus_ready) begin
`ifdef MISALIGNED_SPLIT_EN
                        if (r_state == ACCESS_LO && r_split) begin
                            r_state     <= ACCESS_HI;
                            r_lo_data   <= read_data;
                            address     <= address + ADDR_WIDTH'(B);
                            byte_enable <= r_hi_be;
                            write_data  <= r_hi_wdata;
                        end else
`endif
                        begin
                            r_state      <= RESP;
                            memory_read  <= 1'b0;
                            memory_write <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_error    <= 1'b0;
                            rsp_rdata    <= r_write ? '0 : w_ext;
                        end
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        bus_ready = 1'b0;
    logic [31:0] read_data = '0;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .memory_read(memory_read), .memory_write(memory_write),
        .address(address), .write_data(write_data), .byte_enable(byte_enable),
        .bus_ready(bus_ready), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // Presents a request and returns #1 after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        checks++; if ({memory_read, memory_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {memory_read, memory_write}); end
        checks++; if (address !== 32'h0 || byte_enable !== 4'h0 || write_data !== 32'h0) begin failures++; $display("FAIL reset_bus got addr=%h be=%b wd=%h exp 0", address, byte_enable, write_data); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp got rdata=%h err=%0b exp 0", rsp_rdata, rsp_error); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", req_ready); end
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] exp_rdata);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL lb_ready_before got=%0b exp=1", req_ready); end
        issue(1'b0, 2'd0, uns, 32'h0000_1003, 32'h0);
        checks++; if (memory_read !== 1'b1 || memory_write !== 1'b0) begin failures++; $display("FAIL lb_strobe got rd=%0b wr=%0b exp rd=1 wr=0", memory_read, memory_write); end
        checks++; if (address !== 32'h0000_1000) begin failures++; $display("FAIL lb_addr got=%h exp=00001000", address); end
        checks++; if (byte_enable !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", byte_enable); end
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL lb_busy got ready=%0b rsp_valid=%0b exp 0 0", req_ready, rsp_valid); end
        read_data = 32'h80FF_FFFF; bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL lb_rsp_valid got=%0b exp=1", rsp_valid); end
        checks++; if (rsp_rdata !== exp_rdata) begin failures++; $display("FAIL lb_rdata uns=%0b got=%h exp=%h", uns, rsp_rdata, exp_rdata); end
        checks++; if (rsp_error !== 1'b0 || memory_read !== 1'b0) begin failures++; $display("FAIL lb_after got err=%0b rd=%0b exp 0 0", rsp_error, memory_read); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL lb_idle got rsp_valid=%0b ready=%0b exp 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_store_half();
        issue(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_ABCD);
        checks++; if (memory_write !== 1'b1 || memory_read !== 1'b0) begin failures++; $display("FAIL sh_strobe got wr=%0b rd=%0b exp wr=1 rd=0", memory_write, memory_read); end
        checks++; if (address !== 32'h0) begin failures++; $display("FAIL sh_addr got=%h exp=00000000", address); end
        checks++; if (byte_enable !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", byte_enable); end
        checks++; if (write_data !== 32'hABCD_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd0000", write_data); end
        read_data = 32'hFFFF_FFFF; bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin failures++; $display("FAIL sh_rsp got valid=%0b rdata=%h err=%0b exp 1 0 0", rsp_valid, rsp_rdata, rsp_error); end
        checks++; if (memory_write !== 1'b0) begin failures++; $display("FAIL sh_strobe_drop got=%0b exp=0", memory_write); end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
        read_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            checks++; if (memory_read !== 1'b1 || address !== 32'h10 || byte_enable !== 4'b1111) begin failures++; $display("FAIL ws_hold cyc=%0d got rd=%0b addr=%h be=%b exp 1 00000010 1111", i, memory_read, address, byte_enable); end
            checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL ws_busy cyc=%0d got ready=%0b rsp_valid=%0b exp 0 0", i, req_ready, rsp_valid); end
            bus_ready = (i == 3);
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ws_rsp got valid=%0b rdata=%h exp 1 deadbeef", rsp_valid, rsp_rdata); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL ws_resp_ready got=%0b exp=0", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL ws_pulse got rsp_valid=%0b ready=%0b exp 0 1", rsp_valid, req_ready); end
    endtask

`ifdef MISALIGNED_SPLIT_EN
    task automatic test_split();
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0);
        checks++; if (memory_read !== 1'b1 || address !== 32'h4 || byte_enable !== 4'b1100) begin failures++; $display("FAIL split_lo got rd=%0b addr=%h be=%b exp 1 00000004 1100", memory_read, address, byte_enable); end
        read_data = 32'h4433_2211; bus_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (memory_read !== 1'b1 || address !== 32'h8 || byte_enable !== 4'b0011) begin failures++; $display("FAIL split_hi got rd=%0b addr=%h be=%b exp 1 00000008 0011", memory_read, address, byte_enable); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL split_early_rsp got=%0b exp=0", rsp_valid); end
        read_data = 32'h8877_6655;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h6655_4433 || rsp_error !== 1'b0) begin failures++; $display("FAIL split_rsp got valid=%0b rdata=%h err=%0b exp 1 66554433 0", rsp_valid, rsp_rdata, rsp_error); end
        @(posedge clk); #1;
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'hAABB_CCDD);
        checks++; if (memory_write !== 1'b1 || byte_enable !== 4'b1100 || write_data[31:16] !== 16'hCCDD) begin failures++; $display("FAIL split_st_lo got wr=%0b be=%b wd=%h exp 1 1100 ccdd....", memory_write, byte_enable, write_data); end
        bus_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (address !== 32'h8 || byte_enable !== 4'b0011 || write_data[15:0] !== 16'hAABB) begin failures++; $display("FAIL split_st_hi got addr=%h be=%b wd=%h exp 00000008 0011 ....aabb", address, byte_enable, write_data); end
        @(posedge clk); #1;
        bus_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL split_st_rsp got valid=%0b rdata=%h exp 1 0", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_misaligned();
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL mis_rsp got valid=%0b err=%0b rdata=%h exp 1 1 0", rsp_valid, rsp_error, rsp_rdata); end
        checks++; if (memory_read !== 1'b0 || memory_write !== 1'b0) begin failures++; $display("FAIL mis_no_bus got rd=%0b wr=%0b exp 0 0", memory_read, memory_write); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || memory_read !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mis_after got valid=%0b rd=%0b ready=%0b exp 0 0 1", rsp_valid, memory_read, req_ready); end
    endtask
`endif

    task automatic test_size_error();
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin failures++; $display("FAIL size3_rsp got valid=%0b err=%0b exp 1 1", rsp_valid, rsp_error); end
        checks++; if (memory_read !== 1'b0 || memory_write !== 1'b0) begin failures++; $display("FAIL size3_no_bus got rd=%0b wr=%0b exp 0 0", memory_read, memory_write); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL size3_after got valid=%0b ready=%0b exp 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0);
        read_data = 32'h1234_5678; bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || req_ready !== 1'b0) begin failures++; $display("FAIL b2b_rsp1 got valid=%0b rdata=%h ready=%0b exp 1 12345678 0", rsp_valid, rsp_rdata, req_ready); end
        // Second request waits through RESP and is taken at the end of IDLE.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h0000_000E;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || memory_read !== 1'b0) begin failures++; $display("FAIL b2b_idle got ready=%0b rd=%0b exp 1 0", req_ready, memory_read); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (memory_read !== 1'b1 || address !== 32'hC || byte_enable !== 4'b1100) begin failures++; $display("FAIL b2b_access2 got rd=%0b addr=%h be=%b exp 1 0000000c 1100", memory_read, address, byte_enable); end
        read_data = 32'h8001_1234; bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL b2b_rsp2 got valid=%0b rdata=%h exp 1 ffff8001", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0);
        checks++; if (memory_read !== 1'b1) begin failures++; $display("FAIL rstmid_strobe got=%0b exp=1", memory_read); end
        #2 reset = 1'b1;
        #1;
        checks++; if (memory_read !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_async got rd=%0b ready=%0b exp 0 1", memory_read, req_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0 || memory_read !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_quiet cyc=%0d got valid=%0b rd=%0b ready=%0b exp 0 0 1", i, rsp_valid, memory_read, req_ready); end
        end
        bus_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_wait_states();
`ifdef MISALIGNED_SPLIT_EN
        test_split();
`else
        test_misaligned();
`endif
        test_size_error();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
